// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage
// Brief   : RV32I decode stage; pops fetch words, presents one registered
//           micro-op over valid/ready, halts on ECALL/EBREAK.
// Revision: 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        ic_empty,
  output logic        trg_next_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_class,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic [31:0] out_imm,
  output logic [31:0] out_raw,
  output logic        halted,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        resume
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] c_CLS_ILLEGAL = 4'd0;
  localparam logic [3:0] c_CLS_LUI     = 4'd1;
  localparam logic [3:0] c_CLS_AUIPC   = 4'd2;
  localparam logic [3:0] c_CLS_JAL     = 4'd3;
  localparam logic [3:0] c_CLS_JALR    = 4'd4;
  localparam logic [3:0] c_CLS_BRANCH  = 4'd5;
  localparam logic [3:0] c_CLS_LOAD    = 4'd6;
  localparam logic [3:0] c_CLS_STORE   = 4'd7;
  localparam logic [3:0] c_CLS_OPIMM   = 4'd8;
  localparam logic [3:0] c_CLS_OP      = 4'd9;
  localparam logic [3:0] c_CLS_FENCE   = 4'd10;
  localparam logic [3:0] c_CLS_SYSTEM  = 4'd11;

  localparam logic [0:0] c_S_RUN  = 1'b0;
  localparam logic [0:0] c_S_HALT = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [31:0] r_pc_next;
  logic        w_pop;
  logic [3:0]  w_cls;
  logic        w_rd_en;
  logic [31:0] w_imm;
  logic        w_halt_instr;

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
  assign w_imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign w_imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};
  assign w_imm_u = {instr_in[31:12], 12'h000};
  assign w_imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                    instr_in[20], instr_in[30:21], 1'b0};

  // Every listed opcode ends in 2'b11, so compressed/odd words fall to ILLEGAL.
  always_comb begin
    w_cls   = c_CLS_ILLEGAL;
    w_rd_en = 1'b0;
    w_imm   = 32'h0;
    case (instr_in[6:0])
      c_OP_LUI:    begin w_cls = c_CLS_LUI;    w_rd_en = 1'b1; w_imm = w_imm_u; end
      c_OP_AUIPC:  begin w_cls = c_CLS_AUIPC;  w_rd_en = 1'b1; w_imm = w_imm_u; end
      c_OP_JAL:    begin w_cls = c_CLS_JAL;    w_rd_en = 1'b1; w_imm = w_imm_j; end
      c_OP_JALR:   begin w_cls = c_CLS_JALR;   w_rd_en = 1'b1; w_imm = w_imm_i; end
      c_OP_BRANCH: begin w_cls = c_CLS_BRANCH;                 w_imm = w_imm_b; end
      c_OP_LOAD:   begin w_cls = c_CLS_LOAD;   w_rd_en = 1'b1; w_imm = w_imm_i; end
      c_OP_STORE:  begin w_cls = c_CLS_STORE;                  w_imm = w_imm_s; end
      c_OP_OPIMM:  begin w_cls = c_CLS_OPIMM;  w_rd_en = 1'b1; w_imm = w_imm_i; end
      c_OP_OP:     begin w_cls = c_CLS_OP;     w_rd_en = 1'b1;                  end
      c_OP_FENCE:  begin w_cls = c_CLS_FENCE;                  w_imm = w_imm_i; end
      c_OP_SYSTEM: begin w_cls = c_CLS_SYSTEM;                 w_imm = w_imm_i; end
      default:     begin w_cls = c_CLS_ILLEGAL;                                 end
    endcase
  end

  assign w_halt_instr = (w_cls == c_CLS_SYSTEM) && (instr_in[14:12] == 3'b000);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_S_RUN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = c_S_RUN;
    end else begin
      case (r_state)
        c_S_RUN:  if (w_pop && w_halt_instr) w_state_next = c_S_HALT;
        c_S_HALT: if (resume) w_state_next = c_S_RUN;
        default:  w_state_next = c_S_RUN;
      endcase
    end
  end

  always_comb begin
    w_pop = reset & ~flush & (r_state == c_S_RUN) & ~ic_empty &
            (~out_valid | out_ready);
    trg_next_instr = w_pop;
    halted         = (r_state == c_S_HALT);
  end

  // Flush leaves the stale fields in place; only out_valid is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_pc       <= 32'h0;
      out_class    <= 4'h0;
      out_rd       <= 5'h0;
      out_rs1      <= 5'h0;
      out_rs2      <= 5'h0;
      out_funct3   <= 3'h0;
      out_funct7b5 <= 1'b0;
      out_imm      <= 32'h0;
      out_raw      <= 32'h0;
      r_pc_next    <= RESET_PC;
    end else if (flush) begin
      out_valid <= 1'b0;
      r_pc_next <= flush_pc;
    end else if (w_pop) begin
      out_valid    <= 1'b1;
      out_pc       <= r_pc_next;
      out_class    <= w_cls;
      out_rd       <= w_rd_en ? instr_in[11:7] : 5'h0;
      out_rs1      <= instr_in[19:15];
      out_rs2      <= instr_in[24:20];
      out_funct3   <= instr_in[14:12];
      out_funct7b5 <= instr_in[30];
      out_imm      <= w_imm;
      out_raw      <= instr_in;
      r_pc_next    <= r_pc_next + 32'd4;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Randomized bench for decode_stage with a cycle-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, ic_empty, out_ready, flush, resume;
  logic [31:0] instr_in, flush_pc;
  logic        trg_next_instr, out_valid, out_funct7b5, halted;
  logic [31:0] out_pc, out_imm, out_raw;
  logic [3:0]  out_class;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;

  always #5 clk = ~clk;

  decode_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .ic_empty(ic_empty),
    .trg_next_instr(trg_next_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_imm(out_imm), .out_raw(out_raw), .halted(halted), .flush(flush),
    .flush_pc(flush_pc), .resume(resume)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_valid = 0, m_halt = 0;
  logic [31:0] m_pc_next = 0, m_pc = 0, m_raw = 0, m_imm = 0;
  logic [3:0]  m_cls = 0;
  logic [4:0]  m_rd = 0;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [31:0] imm;
  } dec_t;

  function automatic int fld(input logic [31:0] w, input int hi, input int lo);
    return int'((w >> lo) & ((32'h1 << (hi - lo + 1)) - 1));
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int s, imm_i, imm_s, imm_b, imm_u, imm_j;
    s     = w[31] ? 1 : 0;
    imm_i = -s * 2048 + fld(w, 30, 20);
    imm_s = -s * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 7);
    imm_b = -s * 4096 + fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2;
    imm_u = int'(w & 32'hFFFF_F000);
    imm_j = -s * (1 << 20) + fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2;
    d = '0;
    case (fld(w, 6, 0))
      'h37: begin d.cls = 1;  d.imm = imm_u; end
      'h17: begin d.cls = 2;  d.imm = imm_u; end
      'h6F: begin d.cls = 3;  d.imm = imm_j; end
      'h67: begin d.cls = 4;  d.imm = imm_i; end
      'h63: begin d.cls = 5;  d.imm = imm_b; end
      'h03: begin d.cls = 6;  d.imm = imm_i; end
      'h23: begin d.cls = 7;  d.imm = imm_s; end
      'h13: begin d.cls = 8;  d.imm = imm_i; end
      'h33: begin d.cls = 9;  d.imm = 0;     end
      'h0F: begin d.cls = 10; d.imm = imm_i; end
      'h73: begin d.cls = 11; d.imm = imm_i; end
      default: begin d.cls = 0; d.imm = 0; end
    endcase
    if (d.cls inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9}) d.rd = w[11:7];
    return d;
  endfunction

  function automatic bit exp_pop();
    return reset && !flush && !m_halt && !ic_empty && (!m_valid || out_ready);
  endfunction

  task automatic model_edge();
    bit   pop;
    bit   old_halt;
    dec_t d;
    pop = exp_pop();
    old_halt = m_halt;
    if (!reset) begin
      m_valid = 0; m_halt = 0; m_pc_next = 32'h0;
      m_pc = 0; m_raw = 0; m_imm = 0; m_cls = 0; m_rd = 0;
    end else if (flush) begin
      m_valid = 0; m_halt = 0; m_pc_next = flush_pc;
    end else begin
      if (pop) begin
        d = ref_decode(instr_in);
        m_valid = 1; m_pc = m_pc_next; m_pc_next = m_pc_next + 4;
        m_raw = instr_in; m_cls = d.cls; m_rd = d.rd; m_imm = d.imm;
        if (d.cls == 11 && instr_in[14:12] == 3'b000) m_halt = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (old_halt && resume) m_halt = 0;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halt));
    check("out_pc", out_pc, m_pc);
    check("out_class", 32'(out_class), 32'(m_cls));
    check("out_rd", 32'(out_rd), 32'(m_rd));
    check("out_rs1", 32'(out_rs1), 32'(m_raw[19:15]));
    check("out_rs2", 32'(out_rs2), 32'(m_raw[24:20]));
    check("out_funct3", 32'(out_funct3), 32'(m_raw[14:12]));
    check("out_funct7b5", 32'(out_funct7b5), 32'(m_raw[30]));
    check("out_imm", out_imm, m_imm);
    check("out_raw", out_raw, m_raw);
  endtask

  // Inputs are set at the falling edge; pop is checked before the rising edge.
  task automatic step();
    #1;
    check("trg_next_instr", 32'(trg_next_instr), 32'(exp_pop()));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; ic_empty = 1'b1;
    step(); step();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    case (k)
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h33;
      9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73;
      11: w = ($urandom_range(0, 1) != 0) ? 32'h0010_0073 : 32'h0000_0073;
      default: ;
    endcase
    return w;
  endfunction

  logic [31:0] saved_pc;

  initial begin
    reset = 1'b0; ic_empty = 1'b1; out_ready = 1'b1; flush = 1'b0;
    resume = 1'b0; instr_in = 32'h0; flush_pc = 32'h0;
    step(); step();
    reset = 1'b1;

    // ADDI x1, x0, 5
    instr_in = 32'h0050_0093; ic_empty = 1'b0;
    step();
    ic_empty = 1'b1;
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_class", 32'(out_class), 32'd8);
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_rs1", 32'(out_rs1), 32'd0);
    check("addi_imm", out_imm, 32'd5);
    check("addi_pc", out_pc, 32'h0);

    // LUI then BRANCH back-to-back
    do_reset();
    instr_in = 32'h1234_5137; ic_empty = 1'b0;
    step();
    check("lui_class", 32'(out_class), 32'd1);
    check("lui_rd", 32'(out_rd), 32'd2);
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_pc", out_pc, 32'h0);
    instr_in = 32'hFE00_0EE3;
    #1 check("b2b_pop", 32'(trg_next_instr), 32'd1);
    step();
    ic_empty = 1'b1;
    check("br_class", 32'(out_class), 32'd5);
    check("br_rd", 32'(out_rd), 32'd0);
    check("br_imm", out_imm, 32'hFFFF_FFFC);
    check("br_pc", out_pc, 32'h4);

    // Backpressure
    instr_in = 32'h0020_8133; ic_empty = 1'b0; out_ready = 1'b0;
    step(); step(); step(); step();
    out_ready = 1'b1;
    step(); step();
    ic_empty = 1'b1;
    step(); step();

    // EBREAK halts, resume continues sequentially
    instr_in = 32'h0010_0073; ic_empty = 1'b0;
    step();
    check("ebreak_class", 32'(out_class), 32'd11);
    check("ebreak_halted", 32'(halted), 32'd1);
    saved_pc = out_pc;
    instr_in = 32'h0050_0093;
    step(); step(); step();
    check("halt_nopop", 32'(trg_next_instr), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    step();
    check("resume_pc", out_pc, saved_pc + 32'd4);
    ic_empty = 1'b1;
    step();

    // Flush during a transfer
    instr_in = 32'h0050_0093; ic_empty = 1'b0;
    step();
    flush = 1'b1; flush_pc = 32'h80;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    step();
    check("flush_pc", out_pc, 32'h80);

    // PC wrap
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    step();
    check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", out_pc, 32'h0);

    // All-zero word is illegal; reset mid-stream
    instr_in = 32'h0;
    step();
    check("zero_class", 32'(out_class), 32'd0);
    check("zero_raw", out_raw, 32'd0);
    check("zero_rd", 32'(out_rd), 32'd0);
    check("zero_imm", out_imm, 32'd0);
    reset = 1'b0;
    #1 check("reset_nopop", 32'(trg_next_instr), 32'd0);
    step();
    check("reset_valid", 32'(out_valid), 32'd0);
    reset = 1'b1; instr_in = 32'h0050_0093;
    step();
    check("reset_pc", out_pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 149) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      flush_pc  = $urandom & 32'hFFFF_FFFC;
      resume    = ($urandom_range(0, 3) == 0);
      ic_empty  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr_in  = rand_instr();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
